// File: rtl/frame_packer_pkg.sv
// Shared constants and FSM state encoding for frame_packer.
// The HDR state exists only when FRAME_PACKER_HDR_EN is defined.
package frame_packer_pkg;

    localparam int          SOP_BIT      = 18;
    localparam int          EOP_BIT      = 17;
    localparam logic [15:0] HDR_WORD     = 16'h0000;
    localparam int          SPACE_MARGIN = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
`ifdef FRAME_PACKER_HDR_EN
    localparam logic [2:0] ST_HDR   = 3'd1;
`endif
    localparam logic [2:0] ST_SPACE = 3'd2;
    localparam logic [2:0] ST_REQ   = 3'd3;
    localparam logic [2:0] ST_RECV  = 3'd4;

endpackage

// File: rtl/frame_packer.sv
// frame_packer: streams frames from SDRAM into a downstream FIFO as
// {sop, eop, 0, pixel} words, one burst read at a time.
// Optional feature macro: FRAME_PACKER_HDR_EN -- emit a video-packet
// header word (sop set) ahead of each frame; pixel 0 then has sop clear.
//
// state | meaning
// IDLE  | waiting for frame_en; loads frame address and pixel count
// HDR   | writes the header word (only with FRAME_PACKER_HDR_EN)
// SPACE | waits for enough FIFO room to absorb one full burst
// REQ   | holds rd_req/rd_addr/rd_len until rd_ack
// RECV  | forwards rd_len returned words into the FIFO
module frame_packer
    import frame_packer_pkg::*;
#(
    parameter int          FRAME_PIXELS = 384000,
    parameter int          BURST_LEN    = 256,
    parameter logic [23:0] BASE_ADDR    = 24'h000000,
    parameter int          FIFO_DEPTH   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_en,
    output logic        rd_req,
    output logic [23:0] rd_addr,
    output logic [8:0]  rd_len,
    input  logic        rd_ack,
    input  logic        rd_data_valid,
    input  logic [15:0] rd_data,
    input  logic [9:0]  source_fifo_wrusedw,
    output logic        source_valid,
    output logic [18:0] source_fifo_data,
    output logic        frame_done
);

    // wrusedw lags the true fill level, so keep a small margin on top of a burst
    localparam int SPACE_LIMIT = FIFO_DEPTH - BURST_LEN - SPACE_MARGIN;
    localparam int CNT_W       = $clog2(FRAME_PIXELS + 1);
    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);

    logic [2:0]       state_q, state_d;
    logic [23:0]      addr_q, addr_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] pix_q, pix_d;
    logic [8:0]       len_q, len_d;
    logic [8:0]       rcv_q, rcv_d;
    logic             src_valid_q, src_valid_d;
    logic [18:0]      src_data_q, src_data_d;
    logic             done_q, done_d;
    logic             sop_w, eop_w;

`ifdef FRAME_PACKER_HDR_EN
    assign sop_w = 1'b0;
`else
    assign sop_w = (pix_q == '0);
`endif
    assign eop_w = (pix_q == LAST_PIX);

    // Next-state logic for the sequencer, counters and the FIFO write register
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        pix_d       = pix_q;
        len_d       = len_q;
        rcv_d       = rcv_q;
        src_valid_d = 1'b0;
        src_data_d  = src_data_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_en) begin
                    addr_d   = BASE_ADDR;
                    remain_d = FRAME_CNT;
                    pix_d    = '0;
`ifdef FRAME_PACKER_HDR_EN
                    state_d  = ST_HDR;
`else
                    state_d  = ST_SPACE;
`endif
                end
            end
`ifdef FRAME_PACKER_HDR_EN
            ST_HDR: begin
                src_valid_d          = 1'b1;
                src_data_d           = '0;
                src_data_d[SOP_BIT]  = 1'b1;
                src_data_d[15:0]     = HDR_WORD;
                state_d              = ST_SPACE;
            end
`endif
            ST_SPACE: begin
                if (int'(source_fifo_wrusedw) <= SPACE_LIMIT) begin
                    if (int'(remain_q) >= BURST_LEN) begin
                        len_d = 9'(BURST_LEN);
                    end else begin
                        len_d = 9'(remain_q);
                    end
                    rcv_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (rd_ack) begin
                    addr_d   = addr_q + 24'(len_q);
                    remain_d = remain_q - CNT_W'(len_q);
                    state_d  = ST_RECV;
                end
            end
            ST_RECV: begin
                if (rd_data_valid) begin
                    src_valid_d = 1'b1;
                    src_data_d  = {sop_w, eop_w, 1'b0, rd_data};
                    done_d      = eop_w;
                    pix_d       = pix_q + 1'b1;
                    rcv_d       = rcv_q + 9'd1;
                    if (rcv_q + 9'd1 == len_q) begin
                        state_d = (remain_q == '0) ? ST_IDLE : ST_SPACE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            pix_q       <= '0;
            len_q       <= '0;
            rcv_q       <= '0;
            src_valid_q <= 1'b0;
            src_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            pix_q       <= pix_d;
            len_q       <= len_d;
            rcv_q       <= rcv_d;
            src_valid_q <= src_valid_d;
            src_data_q  <= src_data_d;
            done_q      <= done_d;
        end
    end

    assign rd_req           = (state_q == ST_REQ);
    assign rd_addr          = addr_q;
    assign rd_len           = len_q;
    assign source_valid     = src_valid_q;
    assign source_fifo_data = src_data_q;
    assign frame_done       = done_q;

endmodule

// File: tb/tb_frame_packer.sv
// Randomized self-checking bench for frame_packer (FRAME_PIXELS=10, BURST_LEN=4).
module tb_frame_packer;

    localparam int FP  = 10;
    localparam int BL  = 4;
    localparam int FD  = 1024;
`ifdef FRAME_PACKER_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_en = 1'b0;
    logic        rd_ack = 1'b0;
    logic        rd_data_valid = 1'b0;
    logic [15:0] rd_data = '0;
    logic [9:0]  wrusedw = '0;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic [8:0]  rd_len;
    logic        source_valid;
    logic [18:0] source_fifo_data;
    logic        frame_done;

    frame_packer #(
        .FRAME_PIXELS(FP), .BURST_LEN(BL), .BASE_ADDR(24'h000000), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .frame_en(frame_en),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .source_fifo_wrusedw(wrusedw),
        .source_valid(source_valid), .source_fifo_data(source_fifo_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [18:0] wr_q[$];
    logic [18:0] exp_q[$];
    int obs_addr[$], obs_len[$], exp_addr[$], exp_len[$];
    int done_cnt, unstable_cnt, timeout_cnt;
    int n_tests = 0;
    int n_fail  = 0;
    bit noise_en = 1'b0;

    // Observe FIFO writes and frame_done pulses away from the active edge
    always @(negedge clk) begin
        if (source_valid === 1'b1) wr_q.push_back(source_fifo_data);
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic clear_obs();
        wr_q.delete(); exp_q.delete();
        obs_addr.delete(); obs_len.delete(); exp_addr.delete(); exp_len.delete();
        done_cnt = 0; unstable_cnt = 0; timeout_cnt = 0;
    endtask

    // Reference burst plan for one frame: consecutive chunks of at most BL words
    task automatic add_exp_bursts();
        for (int off = 0; off < FP; off += BL) begin
            exp_addr.push_back(off);
            exp_len.push_back((FP - off < BL) ? FP - off : BL);
        end
    endtask

    // Plays the SDRAM controller for one frame; records requests and expected words
    task automatic serve_frame(input int ack_dly, input int gap_max, input int drop_at);
        int sent;
        int w;
        logic [23:0] a;
        logic [8:0]  l;
        logic [15:0] d;
        sent = 0;
        if (HDR) exp_q.push_back(19'h40000);
        while (sent < FP) begin
            w = 0;
            while (rd_req !== 1'b1 && w < 3000) begin
                if (noise_en) begin
                    rd_data_valid = 1'($urandom);
                    rd_data       = 16'($urandom);
                end
                @(negedge clk);
                w++;
            end
            rd_data_valid = 1'b0;
            if (rd_req !== 1'b1) begin
                timeout_cnt++;
                return;
            end
            a = rd_addr;
            l = rd_len;
            obs_addr.push_back(int'(a));
            obs_len.push_back(int'(l));
            for (int k = 0; k < ack_dly; k++) begin
                @(negedge clk);
                if (rd_req !== 1'b1 || rd_addr !== a || rd_len !== l) unstable_cnt++;
            end
            rd_ack = 1'b1;
            @(negedge clk);
            rd_ack = 1'b0;
            if (l == 0) begin
                timeout_cnt++;
                return;
            end
            for (int i = 0; i < int'(l); i++) begin
                repeat ($urandom_range(gap_max, 0)) @(negedge clk);
                d = 16'($urandom);
                rd_data_valid = 1'b1;
                rd_data = d;
                if (sent == drop_at) frame_en = 1'b0;
                exp_q.push_back({(sent == 0) && !HDR, sent == FP - 1, 1'b0, d});
                sent++;
                @(negedge clk);
                rd_data_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({rd_req, rd_addr, rd_len} !== 34'd0) begin
            n_fail++; $display("FAIL reset_req: got req=%b addr=%h len=%0d, want all 0", rd_req, rd_addr, rd_len);
        end
        n_tests++;
        if ({source_valid, source_fifo_data, frame_done} !== 21'd0) begin
            n_fail++; $display("FAIL reset_src: got valid=%b data=%h done=%b, want all 0", source_valid, source_fifo_data, frame_done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int bad;
        clear_obs();
        wrusedw = '0;
        frame_en = 1'b1;
        add_exp_bursts();
        serve_frame(0, 0, 0);
        repeat (5) @(negedge clk);
        n_tests++;
        if (timeout_cnt != 0 || obs_addr.size() != exp_addr.size()) begin
            n_fail++; $display("FAIL basic_bursts: got %0d bursts (timeouts %0d), want %0d", obs_addr.size(), timeout_cnt, exp_addr.size());
        end else begin
            bad = 0;
            foreach (exp_addr[i]) if (obs_addr[i] != exp_addr[i] || obs_len[i] != exp_len[i]) bad++;
            if (bad != 0) begin
                n_fail++; $display("FAIL basic_bursts: %0d bursts differ, first got (%0d,%0d) want (%0d,%0d)", bad, obs_addr[0], obs_len[0], exp_addr[0], exp_len[0]);
            end
        end
        n_tests++;
        if (wr_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL basic_count: got %0d writes, want %0d", wr_q.size(), exp_q.size());
        end else begin
            bad = 0;
            foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) bad++;
            if (bad != 0) begin
                n_fail++; $display("FAIL basic_words: %0d words differ, last got %h want %h", bad, wr_q[wr_q.size()-1], exp_q[exp_q.size()-1]);
            end
        end
        n_tests++;
        if (done_cnt != 1) begin
            n_fail++; $display("FAIL basic_done: got %0d frame_done pulses, want 1", done_cnt);
        end
    endtask

    task automatic test_threshold();
        int hi;
        int bad;
        clear_obs();
        wrusedw = 10'(FD - BL - 4 + 1);
        frame_en = 1'b1;
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_req === 1'b1) hi++;
        end
        n_tests++;
        if (hi != 0) begin
            n_fail++; $display("FAIL thresh_block: rd_req high %0d cycles at wrusedw=%0d, want 0", hi, wrusedw);
        end
        wrusedw = 10'(FD - BL - 4);
        @(negedge clk);
        n_tests++;
        if (rd_req !== 1'b1) begin
            n_fail++; $display("FAIL thresh_open: rd_req=%b one cycle after wrusedw=%0d, want 1", rd_req, wrusedw);
        end
        add_exp_bursts();
        serve_frame(0, 0, 0);
        repeat (5) @(negedge clk);
        wrusedw = '0;
        bad = (wr_q.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) bad++;
        n_tests++;
        if (bad != 0 || timeout_cnt != 0) begin
            n_fail++; $display("FAIL thresh_stream: %0d word errors, %0d timeouts (got %0d writes, want %0d)", bad, timeout_cnt, wr_q.size(), exp_q.size());
        end
    endtask

    task automatic test_ack_delay();
        int bad;
        clear_obs();
        frame_en = 1'b1;
        add_exp_bursts();
        serve_frame(5, 0, 0);
        repeat (5) @(negedge clk);
        n_tests++;
        if (unstable_cnt != 0 || obs_addr.size() != exp_addr.size()) begin
            n_fail++; $display("FAIL ack_hold: got %0d unstable cycles and %0d bursts, want 0 and %0d", unstable_cnt, obs_addr.size(), exp_addr.size());
        end
        bad = (wr_q.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL ack_stream: got %0d writes with %0d errors, want %0d writes", wr_q.size(), bad, exp_q.size());
        end
    endtask

    task automatic test_random();
        int bad;
        for (int f = 0; f < 4; f++) begin
            clear_obs();
            noise_en = 1'b1;
            frame_en = 1'b1;
            add_exp_bursts();
            serve_frame($urandom_range(3, 0), 2, 0);
            noise_en = 1'b0;
            rd_data_valid = 1'b0;
            repeat (6) @(negedge clk);
            bad = (wr_q.size() != exp_q.size()) ? 1 : 0;
            if (bad == 0) foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) bad++;
            foreach (exp_addr[i]) if (i >= obs_addr.size() || obs_addr[i] != exp_addr[i] || obs_len[i] != exp_len[i]) bad++;
            n_tests++;
            if (bad != 0 || done_cnt != 1 || timeout_cnt != 0) begin
                n_fail++; $display("FAIL random_frame%0d: %0d errors, got %0d writes/%0d done, want %0d writes/1 done", f, bad, wr_q.size(), done_cnt, exp_q.size());
            end
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        clear_obs();
        frame_en = 1'b1;
        add_exp_bursts();
        add_exp_bursts();
        serve_frame(1, 1, -1);
        serve_frame(0, 1, 0);
        repeat (6) @(negedge clk);
        bad = (wr_q.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL b2b_stream: got %0d writes with %0d errors, want %0d writes", wr_q.size(), bad, exp_q.size());
        end
        bad = (obs_addr.size() != exp_addr.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_addr[i]) if (obs_addr[i] != exp_addr[i] || obs_len[i] != exp_len[i]) bad++;
        n_tests++;
        if (bad != 0 || done_cnt != 2) begin
            n_fail++; $display("FAIL b2b_bursts: got %0d bursts (%0d bad), %0d done, want %0d bursts, 2 done", obs_addr.size(), bad, done_cnt, exp_addr.size());
        end
    endtask

    task automatic test_drop_enable();
        int hi;
        int bad;
        clear_obs();
        frame_en = 1'b1;
        add_exp_bursts();
        serve_frame(0, 1, 3);
        hi = 0;
        repeat (50) begin
            @(negedge clk);
            if (rd_req === 1'b1) hi++;
        end
        bad = (wr_q.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) bad++;
        n_tests++;
        if (bad != 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL drop_finish: got %0d writes (%0d bad), %0d done, want %0d writes, 1 done", wr_q.size(), bad, done_cnt, exp_q.size());
        end
        n_tests++;
        if (hi != 0) begin
            n_fail++; $display("FAIL drop_idle: rd_req high %0d cycles after frame, want 0", hi);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        int bad;
        clear_obs();
        frame_en = 1'b1;
        w = 0;
        while (rd_req !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        repeat (2) begin
            rd_data_valid = 1'b1;
            rd_data = 16'($urandom);
            @(negedge clk);
        end
        rd_data_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({rd_req, rd_addr, rd_len, source_valid, source_fifo_data, frame_done} !== 55'd0) begin
            n_fail++; $display("FAIL rstmid_async: got req=%b addr=%h len=%0d valid=%b data=%h done=%b, want all 0",
                               rd_req, rd_addr, rd_len, source_valid, source_fifo_data, frame_done);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if ({rd_req, rd_addr, rd_len, source_valid, source_fifo_data, frame_done} !== 55'd0) begin
            n_fail++; $display("FAIL rstmid_hold: got req=%b addr=%h len=%0d valid=%b data=%h done=%b, want all 0",
                               rd_req, rd_addr, rd_len, source_valid, source_fifo_data, frame_done);
        end
        clear_obs();
        rst = 1'b0;
        add_exp_bursts();
        serve_frame(0, 0, 0);
        repeat (5) @(negedge clk);
        n_tests++;
        if (obs_addr.size() == 0 || obs_addr[0] != 0 || wr_q.size() == 0 || wr_q[0][18] !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_restart: got first addr %0d, %0d writes, want addr 0 and sop on first word",
                               (obs_addr.size() > 0) ? obs_addr[0] : -1, wr_q.size());
        end
        bad = (wr_q.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) bad++;
        n_tests++;
        if (bad != 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL rstmid_stream: got %0d writes (%0d bad), %0d done, want %0d writes, 1 done", wr_q.size(), bad, done_cnt, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_threshold();
        test_ack_delay();
        test_random();
        test_back_to_back();
        test_drop_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_packer.md
FRAME_PACKER -- requirements
Module: frame_packer

Interface
REQ-001 Parameter FRAME_PIXELS, default 384000, gives the number of 16-bit pixels in each frame.
REQ-002 Parameter BURST_LEN, default 256, gives the maximum number of words in one SDRAM read burst (range 1..511).
REQ-003 Parameter BASE_ADDR, default 24'h000000, gives the SDRAM word address of the first pixel of each frame.
REQ-004 Parameter FIFO_DEPTH, default 1024, gives the depth of the downstream dual-clock FIFO.
REQ-005 Port clk, input, 1 bit: the single clock; one clock domain only.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port frame_en, input, 1 bit: while high, frames are streamed back-to-back.
REQ-008 Port rd_req, output, 1 bit: burst read request to the SDRAM controller.
REQ-009 Port rd_addr, output, 24 bits: start word address of the requested burst.
REQ-010 Port rd_len, output, 9 bits: word count of the requested burst.
REQ-011 Port rd_ack, input, 1 bit: single-cycle pulse; the controller has accepted the request.
REQ-012 Port rd_data_valid, input, 1 bit: rd_data carries a read word this cycle.
REQ-013 Port rd_data, input, 16 bits: read data from SDRAM.
REQ-014 Port source_fifo_wrusedw, input, 10 bits: fill level of the downstream FIFO, write side.
REQ-015 Port source_valid, output, 1 bit: write strobe to the downstream FIFO.
REQ-016 Port source_fifo_data, output, 19 bits: downstream FIFO word; bit18 = sop, bit17 = eop, bit16 = 0, bits15:0 = data.
REQ-017 Port frame_done, output, 1 bit: one-cycle pulse when the eop word is written.

Function
REQ-018 The FSM SHALL have states IDLE, HDR, SPACE, REQ and RECV.
REQ-019 In IDLE with frame_en=1, the block SHALL load addr=BASE_ADDR and remaining=FRAME_PIXELS, then go to HDR (macro on) or SPACE (macro off).
REQ-020 SPACE SHALL go to REQ only when source_fifo_wrusedw <= FIFO_DEPTH-BURST_LEN-4; the 4-word margin covers the latency of the wrusedw crossing.
REQ-021 In REQ, rd_req SHALL be 1 and rd_addr and rd_len SHALL stay stable until rd_ack; rd_len = min(BURST_LEN, remaining).
REQ-022 On rd_ack, the block SHALL add rd_len to addr and go to RECV.
REQ-023 In RECV, each rd_data_valid SHALL produce source_valid one cycle later (registered, latency 1), carrying the rd_data word.
REQ-024 The sop bit SHALL be set only on pixel 0 of the frame, and only when the macro is off.
REQ-025 The eop bit SHALL be set only on pixel FRAME_PIXELS-1.
REQ-026 When rd_len words have been received, the block SHALL go to IDLE if remaining=0 (frame_done pulses with the eop write), else to SPACE.
REQ-027 rd_data_valid outside RECV SHALL be ignored; no write to the FIFO results.
REQ-028 frame_en deasserted mid-frame SHALL NOT abort the frame; the frame completes with eop and the FSM then stays in IDLE.
REQ-029 With frame_en held high, the next frame SHALL start from IDLE on the cycle after frame_done.

Reset
REQ-030 While rst=1: state=IDLE; rd_req, rd_addr, rd_len, source_valid, source_fifo_data and frame_done SHALL all be 0; counters SHALL be cleared.
REQ-031 Reset mid-frame SHALL abort the frame with no eop; a partial frame is tolerated downstream.

Configuration
REQ-032 Macro FRAME_PACKER_HDR_EN defined: HDR SHALL emit one word 19'h40000 (sop=1, Avalon-ST video packet type 0), then go to SPACE; pixel 0 SHALL carry sop=0.
REQ-033 Macro FRAME_PACKER_HDR_EN undefined: the HDR state SHALL be absent and sop SHALL be carried on pixel 0.

Structure
REQ-034 Package frame_packer_pkg SHALL hold the state encoding and the constants SOP_BIT=18, EOP_BIT=17, HDR_WORD=16'h0000 and SPACE_MARGIN=4.
REQ-035 The block SHALL be a single module with no sub-module.

Verification (FRAME_PIXELS=10, BURST_LEN=4, FIFO_DEPTH=1024, BASE_ADDR=0, macro off unless stated)
REQ-036 wrusedw=0, frame_en=1, immediate ack -> bursts (addr,len) = (0,4), (4,4), (8,2); 10 writes; sop only on word 0; eop only on word 9; one frame_done.
REQ-037 wrusedw=1017 -> no rd_req; drop to 1016 -> rd_req high on the next cycle.
REQ-038 rd_ack delayed 5 cycles -> rd_req, rd_addr and rd_len constant for all 5 cycles.
REQ-039 FRAME_PACKER_HDR_EN defined -> first write 19'h40000, then 10 pixels; pixel 0 has sop=0; eop on the last pixel.
REQ-040 rst pulsed after 2 words of burst 1 -> outputs 0 while rst is high; restart at addr 0 with sop on the first new word.
REQ-041 frame_en dropped at pixel 3 -> all 10 pixels written with eop, frame_done pulses, then no further rd_req.
